// File: rtl/ram_arbiter_a7_if.sv
// ram_arbiter_a7_if: client-side and memory-side bus bundle for ram_arbiter_a7.
// The slave modport is the arbiter's view; master is the view of the clients
// plus the memory port that surround it.
interface ram_arbiter_a7_if #(
    parameter int NCHAN = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
);
    logic [NCHAN-1:0]    req;
    logic [NCHAN-1:0]    write;
    logic [NCHAN*AW-1:0] addr;
    logic [NCHAN*DW-1:0] data_in;
    logic [NCHAN-1:0]    ready;
    logic [NCHAN-1:0]    done;
    logic [NCHAN*DW-1:0] data_out;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [AW-1:0]       cmd_addr;
    logic [DW-1:0]       cmd_wdata;
    logic                rd_valid;
    logic [DW-1:0]       rd_data;

    modport slave (
        input  req, write, addr, data_in, cmd_ready, rd_valid, rd_data,
        output ready, done, data_out, cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );

    modport master (
        output req, write, addr, data_in, cmd_ready, rd_valid, rd_data,
        input  ready, done, data_out, cmd_valid, cmd_write, cmd_addr, cmd_wdata
    );
endinterface

// File: rtl/ram_arbiter_a7.sv
// ram_arbiter_a7: N-channel round-robin arbiter in front of one DDR3 user
// command port. One transaction is in flight at a time; read data is held
// per channel until that channel's next read completes.
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN -- channel 0 (VGA refresh)
// always wins when requesting; channels 1..NCHAN-1 rotate among themselves.
module ram_arbiter_a7 #(
    parameter int NCHAN = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_arbiter_a7_if.slave       bus,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, FIN} state_t;

    state_t              state;
    logic [2:0]          rr_ptr;
    logic [2:0]          grant_id_r;
    logic                cmd_valid_r;
    logic                cmd_write_r;
    logic [AW-1:0]       cmd_addr_r;
    logic [DW-1:0]       cmd_wdata_r;
    logic [NCHAN-1:0]    done_r;
    logic                ready_r;
    logic                busy_r;
    logic [NCHAN*DW-1:0] data_out_r;

    logic                found;
    logic [2:0]          winner;
    logic                win_write;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic [NCHAN-1:0]    rr_req;
    logic [2:0]          rr_next;

    // Pick the winning channel and mux its write/addr/data for latching in IDLE
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        rr_req = bus.req & {{(NCHAN-1){1'b1}}, 1'b0};
        if (bus.req[0]) begin
            found     = 1'b1;
            winner    = 3'd0;
            win_write = bus.write[0];
            win_addr  = bus.addr[0 +: AW];
            win_wdata = bus.data_in[0 +: DW];
        end
`else
        rr_req = bus.req;
`endif
        for (int k = 0; k < NCHAN; k++) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (!found && rr_req[i] && (i == ((int'(rr_ptr) + k) % NCHAN))) begin
                    found     = 1'b1;
                    winner    = 3'(i);
                    win_write = bus.write[i];
                    win_addr  = bus.addr[i*AW +: AW];
                    win_wdata = bus.data_in[i*DW +: DW];
                end
            end
        end
    end

    // Round-robin pointer moves one past the winner; in fixed-priority builds it skips channel 0
    always_comb begin
        rr_next = 3'd0;
        if (int'(winner) != NCHAN - 1) begin
            rr_next = winner + 3'd1;
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        else begin
            rr_next = 3'd1;
        end
`endif
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id_r  <= '0;
            cmd_valid_r <= 1'b0;
            cmd_write_r <= 1'b0;
            cmd_addr_r  <= '0;
            cmd_wdata_r <= '0;
            done_r      <= '0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            data_out_r  <= '0;
        end else begin
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= ISSUE;
                        grant_id_r  <= winner;
                        cmd_valid_r <= 1'b1;
                        cmd_write_r <= win_write;
                        cmd_addr_r  <= win_addr;
                        cmd_wdata_r <= win_wdata;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
                        if (winner != 3'd0) begin
                            rr_ptr <= rr_next;
                        end
`else
                        rr_ptr <= rr_next;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        if (cmd_write_r) begin
                            state  <= FIN;
                            done_r <= NCHAN'(1) << grant_id_r;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (bus.rd_valid) begin
                        for (int i = 0; i < NCHAN; i++) begin
                            if (i == int'(grant_id_r)) begin
                                data_out_r[i*DW +: DW] <= bus.rd_data;
                            end
                        end
                        done_r <= NCHAN'(1) << grant_id_r;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = {NCHAN{ready_r}};
    assign bus.done      = done_r;
    assign bus.data_out  = data_out_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_write = cmd_write_r;
    assign bus.cmd_addr  = cmd_addr_r;
    assign bus.cmd_wdata = cmd_wdata_r;
    assign busy          = busy_r;
    assign grant_id      = grant_id_r;

endmodule

// File: tb/tb_ram_arbiter_a7.sv
// tb_ram_arbiter_a7: scoreboard bench for ram_arbiter_a7. Each grant the bench
// provokes pushes its expected done/data_out/grant_id; a monitor pops and
// compares on every done pulse. Honours RAM_ARB_FIXED_PRIO_EN if defined.
module tb_ram_arbiter_a7;
    localparam int NCHAN = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    typedef struct {
        logic [NCHAN-1:0]    done_exp;
        logic [NCHAN*DW-1:0] dout_exp;
        logic [2:0]          gid_exp;
    } sb_entry_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                busy;
    logic [2:0]          grant_id;

    int                  checks = 0;
    int                  errors = 0;
    sb_entry_t           sb[$];
    logic [NCHAN*DW-1:0] exp_dout;
    int                  rd_lat = 5;
    logic [DW-1:0]       rd_word = '0;

    ram_arbiter_a7_if #(.NCHAN(NCHAN), .AW(AW), .DW(DW)) bus ();

    ram_arbiter_a7 #(.NCHAN(NCHAN), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int ch, input logic is_write, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[ch]             = 1'b1;
        bus.write[ch]           = is_write;
        bus.addr[ch*AW +: AW]   = a;
        bus.data_in[ch*DW +: DW] = d;
    endtask

    task automatic release_all();
        bus.req   = '0;
        bus.write = '0;
    endtask

    task automatic push_expect(input int ch, input logic is_read, input logic [DW-1:0] rdata);
        sb_entry_t e;
        if (is_read) begin
            exp_dout[ch*DW +: DW] = rdata;
        end
        e.done_exp = NCHAN'(1) << ch;
        e.dout_exp = exp_dout;
        e.gid_exp  = 3'(ch);
        sb.push_back(e);
    endtask

    // Memory model: returns rd_word rd_lat edges after a read command is accepted
    initial begin : mem_model
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            tick();
            if (reset_n && bus.cmd_valid && bus.cmd_ready && !bus.cmd_write) begin
                repeat (rd_lat) @(posedge clk);
                #1;
                bus.rd_valid = 1'b1;
                bus.rd_data  = rd_word;
                tick();
                bus.rd_valid = 1'b0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest scoreboard entry
    initial begin : monitor
        sb_entry_t e;
        forever begin
            tick();
            if (bus.done != '0) begin
                check_value("sb_expected_done", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_value("sb_done", 128'(bus.done), 128'(e.done_exp));
                    check_value("sb_data_out", 128'(bus.data_out), 128'(e.dout_exp));
                    check_value("sb_grant_id", 128'(grant_id), 128'(e.gid_exp));
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin : main_seq
        int n;
        int n_done;
        int total;
        int drop0_at;
        int order[$];

        reset_n       = 1'b0;
        bus.req       = '0;
        bus.write     = '0;
        bus.addr      = '0;
        bus.data_in   = '0;
        bus.cmd_ready = 1'b1;
        exp_dout      = '0;

        tick();
        tick();
        check_value("rst_ready", 128'(bus.ready), 128'(4'hF));
        check_value("rst_busy", 128'(busy), 128'(0));
        check_value("rst_cmd_valid", 128'(bus.cmd_valid), 128'(0));
        check_value("rst_cmd_fields", 128'({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}), 128'(0));
        check_value("rst_done", 128'(bus.done), 128'(0));
        check_value("rst_data_out", 128'(bus.data_out), 128'(0));
        check_value("rst_grant_id", 128'(grant_id), 128'(0));
        reset_n = 1'b1;
        tick();

        // Single write on ch2 with cmd_ready high
        apply_stimulus(2, 1'b1, 22'h12345, 32'hDEADBEEF);
        push_expect(2, 1'b0, '0);
        tick();
        check_value("wr_cmd_valid", 128'(bus.cmd_valid), 128'(1));
        check_value("wr_cmd_write", 128'(bus.cmd_write), 128'(1));
        check_value("wr_cmd_addr", 128'(bus.cmd_addr), 128'(22'h12345));
        check_value("wr_cmd_wdata", 128'(bus.cmd_wdata), 128'(32'hDEADBEEF));
        check_value("wr_busy", 128'(busy), 128'(1));
        check_value("wr_ready_low", 128'(bus.ready), 128'(0));
        release_all();
        tick();
        check_value("wr_done_t2", 128'(bus.done), 128'(4'b0100));
        check_value("wr_data_out", 128'(bus.data_out), 128'(0));
        tick();
        check_value("wr_ready_t3", 128'(bus.ready), 128'(4'hF));

        // Read on ch1, memory answers after a latency
        rd_word = 32'hCAFEF00D;
        apply_stimulus(1, 1'b0, 22'h00ABC, '0);
        push_expect(1, 1'b1, 32'hCAFEF00D);
        tick();
        release_all();
        n = 0;
        while (bus.done == '0 && n < 40) begin
            tick();
            n++;
        end
        check_value("rd_no_timeout", 128'(n < 40), 128'(1));
        check_value("rd_data_ch1", 128'(bus.data_out[DW +: DW]), 128'(32'hCAFEF00D));
        tick();
        check_value("rd_ready", 128'(bus.ready), 128'(4'hF));
        check_value("rd_data_held", 128'(bus.data_out), 128'(exp_dout));

        // Write on ch3 with cmd_ready stalled for 10 cycles
        bus.cmd_ready = 1'b0;
        apply_stimulus(3, 1'b1, 22'h3F00F, 32'h0BADCAFE);
        push_expect(3, 1'b0, '0);
        tick();
        release_all();
        for (int c = 0; c < 10; c++) begin
            check_value("stall_hold",
                        128'({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.done}),
                        128'({1'b1, 1'b1, 22'h3F00F, 32'h0BADCAFE, 4'b0000}));
            tick();
        end
        bus.cmd_ready = 1'b1;
        check_value("stall_no_done", 128'(bus.done), 128'(0));
        tick();
        check_value("stall_done", 128'(bus.done), 128'(4'b1000));
        tick();

        // Continuous requests: fairness order
`ifdef RAM_ARB_FIXED_PRIO_EN
        order    = '{0, 0, 0, 1, 3, 1};
        drop0_at = 3;
        apply_stimulus(0, 1'b1, 22'h00100, 32'h00000010);
        apply_stimulus(1, 1'b1, 22'h00101, 32'h00000011);
        apply_stimulus(3, 1'b1, 22'h00103, 32'h00000013);
`else
        order    = '{0, 1, 2, 3, 0};
        drop0_at = 0;
        for (int ch = 0; ch < NCHAN; ch++) begin
            apply_stimulus(ch, 1'b1, AW'(22'h00100 + ch), DW'(32'h10 + ch));
        end
`endif
        total = order.size();
        foreach (order[j]) begin
            push_expect(order[j], 1'b0, '0);
        end
        n_done = 0;
        n      = 0;
        while (n_done < total && n < 200) begin
            if (bus.done != '0) begin
                n_done++;
                if (n_done == drop0_at) begin
                    bus.req[0] = 1'b0;
                end
                if (n_done == total) begin
                    release_all();
                end
            end
            tick();
            n++;
        end
        check_value("rr_all_served", 128'(n_done), 128'(total));
        release_all();
        tick();
        tick();

        // Reset during WAIT_RD; the late rd_valid must be ignored
        rd_word = 32'h11112222;
        apply_stimulus(2, 1'b0, 22'h02222, '0);
        tick();
        check_value("abort_issue_gid", 128'(grant_id), 128'(2));
        release_all();
        tick();
        check_value("abort_busy_waitrd", 128'(busy), 128'(1));
        reset_n  = 1'b0;
        exp_dout = '0;
        tick();
        check_value("abort_ready", 128'(bus.ready), 128'(4'hF));
        check_value("abort_busy", 128'(busy), 128'(0));
        check_value("abort_data_out", 128'(bus.data_out), 128'(0));
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_value("abort_quiet", 128'({bus.done, bus.data_out}), 128'(0));
        end
        check_value("abort_ready_end", 128'(bus.ready), 128'(4'hF));
        check_value("sb_drained", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
